piece_ctrl: RTL and testbench
=============================

PIECE_CTRL -- requirements
Module: piece_ctrl

Interface
REQ-001 Parameter X_SPAWN, default 3, spawn column of the piece origin.
REQ-002 Parameter Y_SPAWN, default 0, spawn row of the piece origin.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rstn  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  one-cycle pulse; begins a game from IDLE or OVER.
REQ-006 btn_l, btn_r, btn_rot, btn_down  in  1 each  one-cycle move-request pulses.
REQ-007 drop_tick  in  1  one-cycle gravity pulse.
REQ-008 rnd  in  3  random source for the next piece type.
REQ-009 el, er, eu, ed  in  1 each  board flags: left, right, rotate and down legal for the current x/y/type/dir.
REQ-010 overflow  in  1  board flag: the current piece overlaps occupied cells.
REQ-011 refresh_done  in  1  board pulse: lock-in and line clearing complete.
REQ-012 x, y  out  5 each  piece origin column and row.
REQ-013 type  out  3  current piece type, 0..6.
REQ-014 dir  out  2  current rotation, 0..3.
REQ-015 next_type  out  3  preview type, 0..6.
REQ-016 refresh  out  1  one-cycle request to the board to write the piece and clear full rows.
REQ-017 active  out  1  high while the piece accepts moves.
REQ-018 game_over  out  1  high while in OVER.
REQ-019 pieces  out  8  count of locked pieces, saturating at 255.

Function
REQ-020 The FSM SHALL have the states IDLE, SPAWN, CHECK, FALL, SETTLE, LOCK, WAIT_REF and OVER.
REQ-021 IDLE or OVER plus start SHALL lead to SPAWN; this transition SHALL also clear game_over and pieces.
REQ-022 SPAWN SHALL load the following, then go to CHECK:
- x = X_SPAWN, y = Y_SPAWN, dir = 0.
- type = next_type.
- next_type = rnd, with rnd = 7 mapped to 0.
REQ-023 CHECK SHALL last one cycle and then go to OVER if overflow = 1, otherwise to FALL.
REQ-024 The board flags SHALL be sampled only in CHECK and FALL, one cycle after x/y/type/dir change, so the combinational board logic has settled.
REQ-025 FALL SHALL accept at most one event per cycle, in priority order: (drop_tick or btn_down) > btn_rot > btn_l > btn_r; lower-priority events in the same cycle SHALL be dropped.
REQ-026 Gravity event with ed = 1 SHALL set y = y + 1 and go to SETTLE; with ed = 0 it SHALL go to LOCK.
REQ-027 btn_rot with eu = 1 SHALL set dir = dir + 1 modulo 4 (3 wraps to 0) and go to SETTLE.
REQ-028 btn_l with el = 1 SHALL set x = x - 1 and go to SETTLE.
REQ-029 btn_r with er = 1 SHALL set x = x + 1 and go to SETTLE.
REQ-030 An event whose flag is 0 (other than gravity) SHALL be ignored, with no state or output change.
REQ-031 SETTLE SHALL last one cycle, ignore all inputs and return to FALL.
REQ-032 LOCK SHALL assert refresh for exactly one cycle, increment pieces (saturating at 255) and go to WAIT_REF.
REQ-033 WAIT_REF SHALL hold x/y/type/dir stable and go to SPAWN on refresh_done = 1; it SHALL have no timeout.
REQ-034 active SHALL be 1 in CHECK, FALL and SETTLE and 0 in all other states.
REQ-035 game_over SHALL be 1 only in OVER; in OVER all button and tick inputs SHALL be ignored.
REQ-036 start outside IDLE and OVER SHALL be ignored.
REQ-037 refresh_done outside WAIT_REF SHALL be ignored.
REQ-038 Outputs x, y, type, dir, next_type, refresh, active, game_over and pieces SHALL all be registered.

Reset
REQ-039 rstn = 0 SHALL immediately, independent of clk, force:
- state = IDLE.
- x = X_SPAWN, y = Y_SPAWN.
- type = 0, dir = 0, next_type = 0.
- refresh = 0, active = 0, game_over = 0, pieces = 0.
REQ-040 Reset asserted in any state, including mid-WAIT_REF, SHALL abort the operation with no refresh pulse issued after release.

Verification
REQ-041 Reset, then start with rnd = 5 and overflow = 0 -> after SPAWN: type = 0, next_type = 5, x = 3, y = 0, dir = 0; active = 1 two cycles after SPAWN.
REQ-042 In FALL with dir = 3, pulse btn_rot with eu = 1 -> dir = 0; btn_l on the next cycle (SETTLE) -> ignored; btn_l one cycle later with el = 1 -> x = 2.
REQ-043 In FALL, drop_tick and btn_l in the same cycle with ed = el = 1 -> y increments by 1, x unchanged.
REQ-044 drop_tick with ed = 0 -> refresh = 1 for exactly one cycle, active = 0, pieces = 1; refresh_done held low for 10 cycles -> no change; refresh_done pulsed -> SPAWN with new type.
REQ-045 Spawn with overflow = 1 -> game_over = 1 after CHECK, refresh never asserted, buttons ignored; then start -> game_over = 0, pieces = 0, new spawn.
REQ-046 rstn low during WAIT_REF -> all outputs take reset values at once; refresh_done after release -> ignored, state stays IDLE.

Source files
------------

// File: rtl/piece_ctrl.sv
// ---------------------------------------------------------------------------
// piece_ctrl -- falling-piece controller for a block-stacking game.
//
// Owns the position, rotation and type of the active piece, plus the preview
// type. It moves the piece on button or gravity events when the board says
// the move is legal. When a piece can no longer fall, it asks the board to
// lock it in and clear full rows, and then spawns the next piece.
//
// Ports
//   clk           sole clock, rising edge
//   rstn          asynchronous active-low reset
//   start         one-cycle pulse, begins a game from IDLE or OVER
//   btn_l/btn_r   one-cycle move-left / move-right requests
//   btn_rot       one-cycle rotate request
//   btn_down      one-cycle soft-drop request (same effect as drop_tick)
//   drop_tick     one-cycle gravity pulse
//   rnd[2:0]      random source for the next piece type
//   el/er/eu/ed   board legality flags: left, right, rotate, down
//   overflow      board flag: the current piece overlaps occupied cells
//   refresh_done  board pulse: lock-in and line clearing finished
//   x/y[4:0]      piece origin column / row
//   piece_type    current piece type 0..6 (named 'type' at the board level;
//                 'type' is a reserved word in SystemVerilog)
//   dir[1:0]      current rotation
//   next_type     preview piece type 0..6
//   refresh       one-cycle request to the board to write the piece
//   active        high while the piece accepts moves
//   game_over     high while the game is over
//   pieces[7:0]   locked-piece count, saturating at 255
// ---------------------------------------------------------------------------
module piece_ctrl #(
    parameter int X_SPAWN = 3,
    parameter int Y_SPAWN = 0
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start,
    input  logic       btn_l,
    input  logic       btn_r,
    input  logic       btn_rot,
    input  logic       btn_down,
    input  logic       drop_tick,
    input  logic [2:0] rnd,
    input  logic       el,
    input  logic       er,
    input  logic       eu,
    input  logic       ed,
    input  logic       overflow,
    input  logic       refresh_done,
    output logic [4:0] x,
    output logic [4:0] y,
    output logic [2:0] piece_type,
    output logic [1:0] dir,
    output logic [2:0] next_type,
    output logic       refresh,
    output logic       active,
    output logic       game_over,
    output logic [7:0] pieces
);

    localparam logic [4:0] X_INIT = 5'(X_SPAWN);
    localparam logic [4:0] Y_INIT = 5'(Y_SPAWN);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SPAWN    = 3'd1,
        ST_CHECK    = 3'd2,
        ST_FALL     = 3'd3,
        ST_SETTLE   = 3'd4,
        ST_LOCK     = 3'd5,
        ST_WAIT_REF = 3'd6,
        ST_OVER     = 3'd7
    } state_t;

    // Single event chosen in FALL after priority resolution and legality check.
    typedef enum logic [2:0] {
        EV_NONE  = 3'd0,
        EV_DOWN  = 3'd1,
        EV_LOCK  = 3'd2,
        EV_ROT   = 3'd3,
        EV_LEFT  = 3'd4,
        EV_RIGHT = 3'd5
    } event_t;

    state_t state_r;
    event_t event_s;

    // There are only seven piece types; the eighth random code folds onto 0.
    function automatic logic [2:0] rnd_to_type(input logic [2:0] r);
        logic [2:0] t;
        if (r == 3'd7) begin
            t = 3'd0;
        end else begin
            t = r;
        end
        return t;
    endfunction

    // Locked-piece counter that sticks at its maximum.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        logic [7:0] n;
        if (v == 8'hFF) begin
            n = v;
        end else begin
            n = v + 8'd1;
        end
        return n;
    endfunction

    // Pick at most one FALL event. A higher-priority request wins even when it
    // is illegal, so the lower-priority requests in that cycle are dropped.
    always_comb begin
        event_s = EV_NONE;
        if (drop_tick || btn_down) begin
            if (ed) begin
                event_s = EV_DOWN;
            end else begin
                event_s = EV_LOCK;
            end
        end else if (btn_rot) begin
            if (eu) begin
                event_s = EV_ROT;
            end else begin
                event_s = EV_NONE;
            end
        end else if (btn_l) begin
            if (el) begin
                event_s = EV_LEFT;
            end else begin
                event_s = EV_NONE;
            end
        end else if (btn_r) begin
            if (er) begin
                event_s = EV_RIGHT;
            end else begin
                event_s = EV_NONE;
            end
        end else begin
            event_s = EV_NONE;
        end
    end

    // Controller FSM. The outputs are registered alongside the state, so the
    // flags active/refresh/game_over always describe the current state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r    <= ST_IDLE;
            x          <= X_INIT;
            y          <= Y_INIT;
            piece_type <= 3'd0;
            dir        <= 2'd0;
            next_type  <= 3'd0;
            refresh    <= 1'b0;
            active     <= 1'b0;
            game_over  <= 1'b0;
            pieces     <= 8'd0;
        end else begin
            // refresh is a single-cycle strobe unless LOCK is being entered
            refresh <= 1'b0;
            case (state_r)
                ST_IDLE, ST_OVER: begin
                    if (start) begin
                        state_r   <= ST_SPAWN;
                        game_over <= 1'b0;
                        pieces    <= 8'd0;
                    end else begin
                        state_r <= state_r;
                    end
                end

                ST_SPAWN: begin
                    x          <= X_INIT;
                    y          <= Y_INIT;
                    dir        <= 2'd0;
                    piece_type <= next_type;
                    next_type  <= rnd_to_type(rnd);
                    active     <= 1'b1;
                    state_r    <= ST_CHECK;
                end

                // The new piece's coordinates have had one cycle to propagate
                // through the board logic, so overflow is now meaningful.
                ST_CHECK: begin
                    if (overflow) begin
                        state_r   <= ST_OVER;
                        active    <= 1'b0;
                        game_over <= 1'b1;
                    end else begin
                        state_r <= ST_FALL;
                    end
                end

                ST_FALL: begin
                    case (event_s)
                        EV_DOWN: begin
                            y       <= y + 5'd1;
                            state_r <= ST_SETTLE;
                        end
                        EV_LOCK: begin
                            active  <= 1'b0;
                            refresh <= 1'b1;
                            pieces  <= sat_inc(pieces);
                            state_r <= ST_LOCK;
                        end
                        EV_ROT: begin
                            dir     <= dir + 2'd1;
                            state_r <= ST_SETTLE;
                        end
                        EV_LEFT: begin
                            x       <= x - 5'd1;
                            state_r <= ST_SETTLE;
                        end
                        EV_RIGHT: begin
                            x       <= x + 5'd1;
                            state_r <= ST_SETTLE;
                        end
                        default: begin
                            state_r <= ST_FALL;
                        end
                    endcase
                end

                // One dead cycle after each move, so the board flags reflect
                // the new position before the next event is judged.
                ST_SETTLE: begin
                    state_r <= ST_FALL;
                end

                ST_LOCK: begin
                    state_r <= ST_WAIT_REF;
                end

                // Piece stays frozen until the board reports it has finished.
                ST_WAIT_REF: begin
                    if (refresh_done) begin
                        state_r <= ST_SPAWN;
                    end else begin
                        state_r <= ST_WAIT_REF;
                    end
                end

                default: begin
                    state_r   <= ST_IDLE;
                    active    <= 1'b0;
                    game_over <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piece_ctrl.sv
// ---------------------------------------------------------------------------
// tb_piece_ctrl -- self-checking bench for piece_ctrl.
// A behavioural game model predicts every output on every cycle. Directed
// scenarios pin the model with literal values, and random stimulus then
// exercises it broadly.
// ---------------------------------------------------------------------------
module tb_piece_ctrl;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       start = 1'b0, btn_l = 1'b0, btn_r = 1'b0, btn_rot = 1'b0, btn_down = 1'b0;
    logic       drop_tick = 1'b0;
    logic [2:0] rnd = 3'd0;
    logic       el = 1'b0, er = 1'b0, eu = 1'b0, ed = 1'b0, overflow = 1'b0, refresh_done = 1'b0;
    logic [4:0] x, y;
    logic [2:0] piece_type, next_type;
    logic [1:0] dir;
    logic       refresh, active, game_over;
    logic [7:0] pieces;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    piece_ctrl #(.X_SPAWN(3), .Y_SPAWN(0)) dut (
        .clk(clk), .rstn(rstn), .start(start), .btn_l(btn_l), .btn_r(btn_r),
        .btn_rot(btn_rot), .btn_down(btn_down), .drop_tick(drop_tick), .rnd(rnd),
        .el(el), .er(er), .eu(eu), .ed(ed), .overflow(overflow),
        .refresh_done(refresh_done), .x(x), .y(y), .piece_type(piece_type),
        .dir(dir), .next_type(next_type), .refresh(refresh), .active(active),
        .game_over(game_over), .pieces(pieces)
    );

    // ---------------- behavioural model ----------------
    localparam int P_IDLE = 0, P_SPAWN = 1, P_CHECK = 2, P_FALL = 3;
    localparam int P_SETTLE = 4, P_LOCK = 5, P_WAIT = 6, P_OVER = 7;

    typedef struct packed {
        int         phase;
        logic [4:0] px;
        logic [4:0] py;
        logic [2:0] t;
        logic [2:0] nt;
        logic [1:0] d;
        int         placed;   // unbounded count; output is clipped to 255
    } mdl_t;

    mdl_t m;

    function automatic mdl_t model_reset();
        mdl_t r;
        r.phase = P_IDLE; r.px = 5'd3; r.py = 5'd0;
        r.t = 3'd0; r.nt = 3'd0; r.d = 2'd0; r.placed = 0;
        return r;
    endfunction

    function automatic mdl_t model_next(input mdl_t c);
        mdl_t n = c;
        if (c.phase == P_IDLE || c.phase == P_OVER) begin
            if (start) begin
                n.phase = P_SPAWN;
                n.placed = 0;
            end
        end else if (c.phase == P_SPAWN) begin
            n.px = 5'd3; n.py = 5'd0; n.d = 2'd0;
            n.t = c.nt;
            n.nt = 3'(int'(rnd) % 7);
            n.phase = P_CHECK;
        end else if (c.phase == P_CHECK) begin
            n.phase = overflow ? P_OVER : P_FALL;
        end else if (c.phase == P_FALL) begin
            if (drop_tick || btn_down) begin
                if (ed) begin
                    n.py = 5'((int'(c.py) + 1) % 32);
                    n.phase = P_SETTLE;
                end else begin
                    n.placed = c.placed + 1;
                    n.phase = P_LOCK;
                end
            end else if (btn_rot) begin
                if (eu) begin
                    n.d = 2'((int'(c.d) + 1) % 4);
                    n.phase = P_SETTLE;
                end
            end else if (btn_l) begin
                if (el) begin
                    n.px = 5'((int'(c.px) + 31) % 32);
                    n.phase = P_SETTLE;
                end
            end else if (btn_r) begin
                if (er) begin
                    n.px = 5'((int'(c.px) + 1) % 32);
                    n.phase = P_SETTLE;
                end
            end
        end else if (c.phase == P_SETTLE) begin
            n.phase = P_FALL;
        end else if (c.phase == P_LOCK) begin
            n.phase = P_WAIT;
        end else if (c.phase == P_WAIT) begin
            if (refresh_done) n.phase = P_SPAWN;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) m <= model_reset();
        else       m <= model_next(m);
    end

    // ---------------- checking ----------------
    task automatic check(input string nm, input int act, input int exp);
        n_total = n_total + 1;
        if (act == exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    always @(negedge clk) begin
        check("x", int'(x), int'(m.px));
        check("y", int'(y), int'(m.py));
        check("type", int'(piece_type), int'(m.t));
        check("dir", int'(dir), int'(m.d));
        check("next_type", int'(next_type), int'(m.nt));
        check("refresh", int'(refresh), (m.phase == P_LOCK) ? 1 : 0);
        check("active", int'(active),
              (m.phase == P_CHECK || m.phase == P_FALL || m.phase == P_SETTLE) ? 1 : 0);
        check("game_over", int'(game_over), (m.phase == P_OVER) ? 1 : 0);
        check("pieces", int'(pieces), (m.placed > 255) ? 255 : m.placed);
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_pulses();
        start = 1'b0; btn_l = 1'b0; btn_r = 1'b0; btn_rot = 1'b0;
        btn_down = 1'b0; drop_tick = 1'b0; refresh_done = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        // reset state
        check("rst_x", int'(x), 3);
        check("rst_y", int'(y), 0);
        check("rst_next", int'(next_type), 0);
        check("rst_active", int'(active), 0);
        rstn = 1'b1;

        // start with rnd = 5: spawn loads type 0 and preview 5
        rnd = 3'd5; start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        check("spawn_type", int'(piece_type), 0);
        check("spawn_next", int'(next_type), 5);
        check("spawn_x", int'(x), 3);
        check("spawn_active", int'(active), 1);

        // rotate three times to reach dir = 3
        eu = 1'b1; el = 1'b1; er = 1'b1; ed = 1'b1;
        cyc();                                  // CHECK -> FALL
        for (int i = 0; i < 3; i++) begin
            btn_rot = 1'b1; cyc();
            btn_rot = 1'b0; cyc();
        end
        check("dir3", int'(dir), 3);
        btn_rot = 1'b1; cyc();
        btn_rot = 1'b0;
        check("dir_wrap", int'(dir), 0);
        btn_l = 1'b1; cyc();                    // SETTLE ignores it
        check("settle_ignore_x", int'(x), 3);
        cyc();                                  // FALL takes it
        btn_l = 1'b0;
        check("left_x", int'(x), 2);
        cyc();

        // gravity beats left in the same cycle
        drop_tick = 1'b1; btn_l = 1'b1; cyc();
        clear_pulses();
        check("prio_y", int'(y), 1);
        check("prio_x", int'(x), 2);
        cyc();

        // lock: one refresh pulse, then wait indefinitely for refresh_done
        ed = 1'b0; drop_tick = 1'b1; cyc();
        drop_tick = 1'b0;
        check("lock_refresh", int'(refresh), 1);
        check("lock_active", int'(active), 0);
        check("lock_pieces", int'(pieces), 1);
        cyc();
        check("refresh_once", int'(refresh), 0);
        repeat (10) cyc();
        check("wait_refresh", int'(refresh), 0);
        check("wait_y", int'(y), 1);
        refresh_done = 1'b1; cyc();
        refresh_done = 1'b0;
        ed = 1'b1; overflow = 1'b1;
        cyc();                                  // SPAWN -> CHECK
        check("respawn_type", int'(piece_type), 5);

        // overflow in CHECK ends the game; inputs are ignored in OVER
        cyc();
        check("over", int'(game_over), 1);
        for (int i = 0; i < 6; i++) begin
            drop_tick = 1'b1; btn_l = 1'b1; btn_rot = 1'b1; refresh_done = 1'b1; cyc();
        end
        clear_pulses();
        check("over_refresh", int'(refresh), 0);
        check("over_x", int'(x), 3);
        overflow = 1'b0; start = 1'b1; cyc();
        start = 1'b0;
        check("restart_go", int'(game_over), 0);
        check("restart_pieces", int'(pieces), 0);
        cyc();
        check("restart_active", int'(active), 1);

        // reset in the middle of WAIT_REF
        cyc();
        ed = 1'b0; drop_tick = 1'b1; cyc();
        drop_tick = 1'b0; cyc();
        #2 rstn = 1'b0;
        #1;
        check("ar_type", int'(piece_type), 0);
        check("ar_next", int'(next_type), 0);
        check("ar_pieces", int'(pieces), 0);
        check("ar_refresh", int'(refresh), 0);
        @(negedge clk);
        rstn = 1'b1; refresh_done = 1'b1; cyc();
        refresh_done = 1'b0;
        repeat (3) cyc();
        check("ar_idle_active", int'(active), 0);
        check("ar_idle_refresh", int'(refresh), 0);

        // randomized play
        for (int i = 0; i < 3000; i++) begin
            rnd          = 3'($urandom_range(0, 7));
            start        = ($urandom_range(0, 7) == 0);
            btn_l        = ($urandom_range(0, 3) == 0);
            btn_r        = ($urandom_range(0, 3) == 0);
            btn_rot      = ($urandom_range(0, 3) == 0);
            btn_down     = ($urandom_range(0, 9) == 0);
            drop_tick    = ($urandom_range(0, 5) == 0);
            el           = 1'($urandom_range(0, 1));
            er           = 1'($urandom_range(0, 1));
            eu           = 1'($urandom_range(0, 1));
            ed           = ($urandom_range(0, 3) != 0);
            overflow     = ($urandom_range(0, 5) == 0);
            refresh_done = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 299) == 0) begin
                #2 rstn = 1'b0;
                @(negedge clk);
                rstn = 1'b1;
            end else begin
                cyc();
            end
        end

        // saturation of the piece counter
        clear_pulses();
        el = 1'b0; er = 1'b0; eu = 1'b0; ed = 1'b0; overflow = 1'b0;
        #2 rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1; start = 1'b1; cyc();
        start = 1'b0; drop_tick = 1'b1; refresh_done = 1'b1;
        repeat (1400) cyc();
        clear_pulses();
        check("sat_pieces", int'(pieces), 255);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
